// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP camera capture block: FSM states,
// RGB565 byte-field positions and the default frame geometry.
package cam_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_FRAME,
    S_LINE
  } cam_state_t;

  localparam int EXP_WIDTH_DEFAULT  = 640;
  localparam int EXP_HEIGHT_DEFAULT = 480;

  // RGB565 arrives as a high byte {R5, G6[5:3]} then a low byte {G6[2:0], B5}
  localparam int R5_MSB  = 7;
  localparam int R5_LSB  = 3;
  localparam int G6H_MSB = 2;
  localparam int G6L_MSB = 7;
  localparam int G6L_LSB = 5;
  localparam int B5_MSB  = 4;

  function automatic logic [23:0] rgb565_to_888(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = hi[R5_MSB:R5_LSB];
    g6 = {hi[G6H_MSB:0], lo[G6L_MSB:G6L_LSB]};
    b5 = lo[B5_MSB:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/cam_dvp_sync.sv
// Synchronizes the raw DVP pins into clk and produces registered edge strobes,
// with data and HREF level aligned to the same depth as the PCLK edge.
module cam_dvp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_d,
  output logic       pclk_rise,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       href_rise,
  output logic       href_fall,
  output logic       href_s,
  output logic [7:0] d_s
);

  logic [SYNC_STAGES-1:0] pclk_sr;
  logic [SYNC_STAGES-1:0] vs_sr;
  logic [SYNC_STAGES-1:0] href_sr;
  logic [7:0]             d_sr [SYNC_STAGES];
  logic                   pclk_d;
  logic                   vs_d;
  logic                   href_d;

  // The *_d flops are the extra delay stage that the edge detectors compare against
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_sr   <= '0;
      vs_sr     <= '0;
      href_sr   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) d_sr[i] <= '0;
      pclk_d    <= 1'b0;
      vs_d      <= 1'b0;
      href_d    <= 1'b0;
      pclk_rise <= 1'b0;
      vs_rise   <= 1'b0;
      vs_fall   <= 1'b0;
      href_rise <= 1'b0;
      href_fall <= 1'b0;
      href_s    <= 1'b0;
      d_s       <= '0;
    end else begin
      pclk_sr <= {pclk_sr[SYNC_STAGES-2:0], cam_pclk};
      vs_sr   <= {vs_sr[SYNC_STAGES-2:0], cam_vsync};
      href_sr <= {href_sr[SYNC_STAGES-2:0], cam_href};
      d_sr[0] <= cam_d;
      for (int i = 1; i < SYNC_STAGES; i++) d_sr[i] <= d_sr[i-1];
      pclk_d    <= pclk_sr[SYNC_STAGES-1];
      vs_d      <= vs_sr[SYNC_STAGES-1];
      href_d    <= href_sr[SYNC_STAGES-1];
      pclk_rise <= pclk_sr[SYNC_STAGES-1] & ~pclk_d;
      vs_rise   <= vs_sr[SYNC_STAGES-1] & ~vs_d;
      vs_fall   <= ~vs_sr[SYNC_STAGES-1] & vs_d;
      href_rise <= href_sr[SYNC_STAGES-1] & ~href_d;
      href_fall <= ~href_sr[SYNC_STAGES-1] & href_d;
      href_s    <= href_sr[SYNC_STAGES-1];
      d_s       <= d_sr[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP RGB565 capture into an RGB888 pixel stream with coordinates and markers.
// Optional statistics counters are built when CAM_CAPTURE_STATS_EN is defined.
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int X_BITS      = 12,
  parameter int Y_BITS      = 12,
  parameter int EXP_WIDTH   = EXP_WIDTH_DEFAULT,
  parameter int EXP_HEIGHT  = EXP_HEIGHT_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              pix_valid,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic [X_BITS-1:0] pix_x,
  output logic [Y_BITS-1:0] pix_y,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count
);

  localparam logic [X_BITS-1:0] W_FULL = X_BITS'(EXP_WIDTH);
  localparam logic [X_BITS-1:0] W_LAST = X_BITS'(EXP_WIDTH - 1);
  localparam logic [Y_BITS-1:0] H_FULL = Y_BITS'(EXP_HEIGHT);

  logic pclk_rise, vs_rise, vs_fall, href_rise, href_fall, href_s;
  logic [7:0] d_s;

  cam_dvp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_d     (cam_d),
    .pclk_rise (pclk_rise),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .href_rise (href_rise),
    .href_fall (href_fall),
    .href_s    (href_s),
    .d_s       (d_s)
  );

  cam_state_t state, next_state;
  logic [X_BITS-1:0] x_cnt;
  logic [Y_BITS-1:0] y_cnt, y_next;
  logic phase, err;
  logic [7:0] hi_byte;
  logic [23:0] rgb;
  logic frame_start, line_start, line_end, frame_end, abort, take_hi, take_lo;
  logic line_err, frame_bad;

  assign rgb  = rgb565_to_888(hi_byte, d_s);
  assign busy = (state == S_FRAME) || (state == S_LINE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // A VSYNC rise outranks everything; in S_LINE a coincident HREF fall still closes the line
  always_comb begin
    next_state  = state;
    frame_start = 1'b0;
    line_start  = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;
    abort       = 1'b0;
    take_hi     = 1'b0;
    take_lo     = 1'b0;
    case (state)
      S_IDLE: if (enable) next_state = S_WAIT_VS;
      S_WAIT_VS: if (vs_fall) begin
        next_state  = S_FRAME;
        frame_start = 1'b1;
      end
      S_FRAME: begin
        if (vs_rise) begin
          frame_end  = 1'b1;
          next_state = enable ? S_WAIT_VS : S_IDLE;
        end else if (href_rise) begin
          line_start = 1'b1;
          next_state = S_LINE;
        end
      end
      S_LINE: begin
        line_end = href_fall;
        if (vs_rise) begin
          frame_end  = 1'b1;
          abort      = 1'b1;
          next_state = enable ? S_WAIT_VS : S_IDLE;
        end else if (href_fall) begin
          next_state = S_FRAME;
        end else if (pclk_rise && href_s) begin
          take_hi = ~phase;
          take_lo = phase;
        end
      end
      default: next_state = S_IDLE;
    endcase
    line_err  = line_end && (phase || (x_cnt != W_FULL));
    y_next    = (line_end && (y_cnt != '1)) ? y_cnt + Y_BITS'(1) : y_cnt;
    frame_bad = err | line_err | abort | (y_next != H_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      frame_err <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      phase     <= 1'b0;
      hi_byte   <= '0;
      err       <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      eof       <= frame_end;
      frame_err <= frame_end & frame_bad;
      err       <= frame_start ? 1'b0 : (err | line_err | abort);
      if (frame_start) y_cnt <= '0;
      if (line_end) begin
        y_cnt <= y_next;
        phase <= 1'b0;
      end
      if (line_start) begin
        x_cnt <= '0;
        phase <= 1'b0;
      end
      if (take_hi) begin
        hi_byte <= d_s;
        phase   <= 1'b1;
      end
      // Out-of-geometry pixels still advance the saturating counter but stay silent
      if (take_lo) begin
        phase <= 1'b0;
        if (x_cnt != '1) x_cnt <= x_cnt + X_BITS'(1);
        if ((x_cnt < W_FULL) && (y_cnt < H_FULL)) begin
          pix_valid <= 1'b1;
          {pix_r, pix_g, pix_b} <= rgb;
          pix_x <= x_cnt;
          pix_y <= y_cnt;
          sof   <= (x_cnt == '0) && (y_cnt == '0);
          eol   <= (x_cnt == W_LAST);
        end
      end
    end
  end

`ifdef CAM_CAPTURE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else if (frame_end) begin
      frame_count <= frame_count + 16'd1;
      if (frame_bad && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Self-checking bench for cam_dvp_capture on a reduced 8x6 geometry, with a
// queue-based reference model of the expected pixel and end-of-frame stream.
module tb_cam_dvp_capture;

  localparam int W = 8;
  localparam int H = 6;
`ifdef CAM_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, enable, cam_pclk, cam_vsync, cam_href;
  logic [7:0] cam_d;
  logic pix_valid, sof, eol, eof, frame_err, busy;
  logic [7:0] pix_r, pix_g, pix_b, err_count;
  logic [11:0] pix_x, pix_y;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  cam_dvp_capture #(
    .X_BITS(12), .Y_BITS(12), .EXP_WIDTH(W), .EXP_HEIGHT(H), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .eof(eof),
    .frame_err(frame_err), .busy(busy), .frame_count(frame_count), .err_count(err_count)
  );

  typedef struct { logic [7:0] hi, lo, r, g, b; } color_vec_t;
  typedef struct { logic [7:0] r, g, b; int x, y; bit sof, eol; int t; } pix_exp_t;
  typedef struct { bit err; int t; } eof_exp_t;

  color_vec_t tbl [8];
  pix_exp_t pq[$];
  eof_exp_t eq[$];
  pix_exp_t mon_p;
  eof_exp_t mon_f;
  int checks = 0, errors = 0, cyc = 0;
  int line_px [16];
  bit line_odd [16];
  bit cap = 1'b0, use_tbl = 1'b0;
  int rst_line = -1, rst_px = -1, last_rise = 0;
  int exp_fc = 0, exp_ec = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Reference colour expansion from field arithmetic
  function automatic logic [23:0] model_rgb(input int hi, input int lo);
    int r5, g6, b5;
    r5 = hi / 8;
    g6 = (hi % 8) * 8 + lo / 32;
    b5 = lo % 32;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  // Output monitor, sampling 1 time unit after each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (pix_valid) begin
      if (pq.size() == 0) check_output("unexpected_pixel", 1, 0);
      else begin
        mon_p = pq.pop_front();
        check_output("pix_rgb", {pix_r, pix_g, pix_b}, {mon_p.r, mon_p.g, mon_p.b});
        check_output("pix_xy", {pix_x, pix_y}, {12'(mon_p.x), 12'(mon_p.y)});
        check_output("pix_sof_eol", {sof, eol}, {mon_p.sof, mon_p.eol});
        check_output("pix_latency", cyc - mon_p.t, 4);
      end
    end
    if (eof) begin
      if (eq.size() == 0) check_output("unexpected_eof", 1, 0);
      else begin
        mon_f = eq.pop_front();
        check_output("eof_frame_err", frame_err, mon_f.err);
        check_output("eof_latency", cyc - mon_f.t, 4);
        exp_fc++;
        if (mon_f.err && exp_ec < 255) exp_ec++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_output({tag, "_flags"}, {pix_valid, sof, eol, eof, frame_err, busy}, 6'd0);
    check_output({tag, "_rgb"}, {pix_r, pix_g, pix_b}, 24'd0);
    check_output({tag, "_xy"}, {pix_x, pix_y}, 24'd0);
    check_output({tag, "_stats"}, {frame_count, err_count}, 24'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_d = b;
    repeat (2) @(negedge clk);
    cam_pclk  = 1'b1;
    last_rise = cyc;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    check_all_zero("reset_mid_line");
    @(negedge clk);
    reset  = 1'b0;
    cap    = 1'b0;
    exp_fc = 0;
    exp_ec = 0;
  endtask

  task automatic send_line(input int y, input int npix, input bit odd);
    logic [7:0] hi, lo;
    logic [23:0] rgb;
    pix_exp_t e;
    cam_href = 1'b1;
    repeat (2) @(negedge clk);
    for (int x = 0; x < npix; x++) begin
      if (use_tbl && y == 0 && x < 8) begin
        hi  = tbl[x].hi;
        lo  = tbl[x].lo;
        rgb = {tbl[x].r, tbl[x].g, tbl[x].b};
      end else begin
        hi  = 8'($urandom_range(0, 255));
        lo  = 8'($urandom_range(0, 255));
        rgb = model_rgb(int'(hi), int'(lo));
      end
      send_byte(hi);
      if (y == rst_line && x == rst_px) pulse_reset();
      send_byte(lo);
      if (cap && x < W && y < H) begin
        e = '{rgb[23:16], rgb[15:8], rgb[7:0], x, y, (x == 0 && y == 0), (x == W - 1), last_rise};
        pq.push_back(e);
      end
    end
    if (odd) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    cam_href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int nlines, input bit capture, input int en_line, input bit en_val);
    bit bad;
    bad = (nlines != H);
    cap = capture;
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      if (l == en_line) enable = en_val;
      if (cap) check_output("busy_in_frame", busy, 1);
      send_line(l, line_px[l], line_odd[l]);
      bad = bad | (line_px[l] != W) | line_odd[l];
    end
    cam_vsync = 1'b1;
    if (cap) eq.push_back('{bad, cyc});
    repeat (8) @(negedge clk);
    for (int l = 0; l < 16; l++) begin
      line_px[l]  = W;
      line_odd[l] = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{8'hF8, 8'h00, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{8'h07, 8'hE0, 8'h00, 8'hFF, 8'h00};
    tbl[2] = '{8'h00, 8'h1F, 8'h00, 8'h00, 8'hFF};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{8'h84, 8'h10, 8'h84, 8'h82, 8'h84};
    tbl[6] = '{8'h52, 8'hAA, 8'h52, 8'h55, 8'h52};
    tbl[7] = '{8'h08, 8'h21, 8'h08, 8'h04, 8'h08};
    for (int l = 0; l < 16; l++) begin
      line_px[l]  = W;
      line_odd[l] = 1'b0;
    end
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; cam_d = 8'h00;
    enable = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset_state");
    enable = 1'b1;
    repeat (8) @(negedge clk);

    use_tbl = 1'b1;
    apply_stimulus(H, 1'b1, -1, 1'b0);
    use_tbl = 1'b0;
    apply_stimulus(H, 1'b1, -1, 1'b0);

    line_px[2]  = W - 1;
    line_odd[2] = 1'b1;
    apply_stimulus(H, 1'b1, -1, 1'b0);

    line_px[1] = W + 2;
    apply_stimulus(H + 2, 1'b1, 2, 1'b0);
    repeat (10) @(negedge clk);
    check_output("busy_after_disable", busy, 0);

    apply_stimulus(H, 1'b0, 2, 1'b1);
    apply_stimulus(H, 1'b1, -1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("frame_count", frame_count, STATS ? exp_fc : 0);
    check_output("err_count", err_count, STATS ? exp_ec : 0);

    rst_line = 3;
    rst_px   = 2;
    apply_stimulus(H, 1'b1, -1, 1'b0);
    rst_line = -1;
    apply_stimulus(H, 1'b1, -1, 1'b0);
    repeat (10) @(negedge clk);
    check_output("frame_count_after_reset", frame_count, STATS ? exp_fc : 0);
    check_output("err_count_after_reset", err_count, STATS ? exp_ec : 0);
    check_output("pixels_outstanding", pq.size(), 0);
    check_output("eofs_outstanding", eq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    check_output("watchdog_timeout", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_dvp_capture.md
# cam_dvp_capture

Captures an 8-bit DVP camera stream (PCLK/VSYNC/HREF/D[7:0], RGB565 two bytes per pixel) by oversampling it on the 50 MHz system clock, then emits RGB888 pixels with x/y coordinates and frame/line markers. Sits upstream of the HDMI video path: its pixel stream is what the frame store and the `r_in/g_in/b_in` inputs of the pattern/timing stage consume in place of fixed defaults. Camera PCLK must be ≤ 1/4 of `clk`.

## Interface
- `X_BITS`, 12: width of `pix_x`.
- `Y_BITS`, 12: width of `pix_y`.
- `EXP_WIDTH`, 640: expected pixels per line.
- `EXP_HEIGHT`, 480: expected lines per frame.
- `SYNC_STAGES`, 2: flip-flop stages on every camera input; legal values are ≥ 2.

- `clk` input 1: system clock, the same 50 MHz clock that drives the video path.
- `reset` input 1: **one clock; reset is synchronous and active-high.**
- `enable` input 1: arms capture. It is sampled only at frame boundaries.
- `cam_pclk`, `cam_vsync`, `cam_href` input 1 each: raw camera pins, asynchronous to `clk`. `vsync` is active-high between frames; `href` is high while line bytes are valid.
- `cam_d` input 8: camera data, valid on the PCLK rising edge.
- `pix_valid` output 1: one-cycle strobe marking a pixel.
- `pix_r`, `pix_g`, `pix_b` output 8 each: expanded pixel colour.
- `pix_x` output X_BITS, `pix_y` output Y_BITS: coordinates of the current pixel.
- `sof`, `eol` output 1 each: qualified by `pix_valid`. `sof` marks the first pixel of a frame; `eol` marks the last pixel of a line.
- `eof` output 1: one-cycle strobe at the VSYNC rise that ends a frame.
- `frame_err` output 1: valid with `eof`. High if the frame had the wrong geometry.
- `busy` output 1: high while in `S_FRAME` or `S_LINE`.
- `frame_count` output 16, `err_count` output 8: statistics counters (see Configuration).

## Operation
- Every camera input passes through `SYNC_STAGES` flip-flops. A PCLK rise is detected from one extra delay stage. `d`, `href` and `vsync` are taken from the same synchronizer depth as the PCLK edge.
- States: `S_IDLE`, `S_WAIT_VS`, `S_FRAME`, `S_LINE`.
  - `S_IDLE`: moves to `S_WAIT_VS` when `enable` = 1.
  - `S_WAIT_VS`: waits for a synchronized VSYNC fall, then goes to `S_FRAME` with y = 0. This guarantees capture never starts mid-frame.
  - `S_FRAME`: an HREF rise goes to `S_LINE` with x = 0 and the byte phase cleared. A VSYNC rise asserts `eof`, then goes to `S_WAIT_VS` if `enable` = 1, otherwise `S_IDLE`.
  - `S_LINE`: on each PCLK edge with HREF high:
    - Phase 0 stores the high byte `{R5, G6[5:3]}`.
    - Phase 1 combines it with the low byte `{G6[2:0], B5}` and issues a pixel.
    - An HREF fall increments y and returns to `S_FRAME`. A VSYNC rise while in `S_LINE` aborts the line, sets the error, and is then handled as in `S_FRAME`.
- Colour expansion: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
- `eol` is asserted on the pixel where x = EXP_WIDTH−1. `sof` is asserted on the pixel where x = 0 and y = 0.
- Error sources, all latched into an internal `err` bit that clears when a frame starts:
  - HREF falls with a phase-0 byte pending; the partial byte is dropped.
  - The line length is not equal to EXP_WIDTH.
  - The line count at `eof` is not equal to EXP_HEIGHT.
  - A VSYNC rise occurs in `S_LINE`.
- Pixels with x ≥ EXP_WIDTH or y ≥ EXP_HEIGHT are suppressed (no `pix_valid`). Their counters saturate and do not wrap.
- Deasserting `enable` mid-frame lets the current frame finish; capture stops at `eof`.

## Timing
- Pin-to-output latency: a phase-1 PCLK rise on the pin produces `pix_valid` SYNC_STAGES+2 `clk` cycles later, which is 4 cycles at default.
- `pix_*`, `pix_x`, `pix_y`, `sof` and `eol` are registered and change only when `pix_valid` is high; they hold their values otherwise.
- `eof` and `frame_err` appear SYNC_STAGES+2 cycles after the VSYNC rise on the pin.
- Reset values: all outputs 0, state `S_IDLE`, synchronizers 0.
- Reset mid-frame has an immediate effect: no `eof` is emitted and counters clear.
- If HREF falls and VSYNC rises on the same cycle: the line closes first, then `eof` is issued with the error set.

## Configuration
- `CAM_CAPTURE_STATS_EN`:
  - Defined: `frame_count` increments on every `eof` and wraps at 16 bits. `err_count` increments on every `eof` with `frame_err` and saturates at 255.
  - Undefined: both ports are tied to 0 and no counter logic is built.

## Structure
- Shared package `cam_pkg` holds:
  - the state enum;
  - the RGB565 field positions;
  - the default EXP_WIDTH/EXP_HEIGHT constants.
- Sub-module `cam_dvp_sync` contains the N-stage synchronizer and PCLK/VSYNC/HREF edge detection, and outputs `pclk_rise`, `vs_rise`, `vs_fall`, `href_rise`, `href_fall`, and `d_s`.

## Test plan
- **Nominal frame.** Stimulus: 640×480 frame, PCLK = clk/4, byte pairs 0xF8 0x00. Required: 307200 `pix_valid` with RGB = FF/00/00; `sof` once at (0,0); 480 `eol`; `eof` with `frame_err` = 0.
- **Colour expansion.** Stimulus: bytes 0x07 0xE0, then 0x00 0x1F. Required: RGB = 00/FF/00, then 00/00/FF.
- **Short line.** Stimulus: line 5 carries 639 pixels plus one odd byte. Required: 639 pixels on that line; `eof` with `frame_err` = 1; `err_count` = 1 (stats enabled).
- **Late arm.** Stimulus: `enable` raised mid-frame. Required: no `pix_valid` until after the next VSYNC fall; the first captured pixel carries `sof`.
- **Enable drop and oversize.** Stimulus: `enable` dropped at line 100, with 482 lines sent. Required: the current frame completes; lines 480–481 are suppressed; `frame_err` = 1; the block returns to `S_IDLE` with `busy` = 0.
- **Reset mid-line.** Stimulus: `reset` held one cycle mid-line. Required: all outputs 0 on the next cycle and no `eof`; after re-arm, capture resumes at the following frame.
